// File: rtl/sfla40_16x8bw16_pkg.sv
// Shared constants, entry layout and operation decode for the sfla40_16x8bw16 ternary CAM.
package sfla_pkg;

  localparam int WORDS  = 16;
  localparam int BITS   = 8;
  localparam int ADDR_W = 4;
  localparam int BANKS  = 1;

  typedef struct packed {
    logic [BITS-1:0] data;
    logic [BITS-1:0] care;
    logic            valid;
  } entry_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_FLUSH,
    OP_WR,
    OP_RD,
    OP_CMP
  } op_t;

  // At most one operation runs per edge; FLUSH outranks WR, RD, CMP in that order.
  function automatic op_t decode_op(input logic             cs,
                                    input logic [BANKS-1:0] cbe,
                                    input logic             flush,
                                    input logic             wr,
                                    input logic             rd,
                                    input logic             cmp);
    if (!cs || (cbe != '0)) return OP_NONE;
    if (flush)              return OP_FLUSH;
    if (wr)                 return OP_WR;
    if (rd)                 return OP_RD;
    if (cmp)                return OP_CMP;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/sfla40_16x8bw16_if.sv
// Command/data bus of the sfla40_16x8bw16 CAM; the controller drives it as master.
interface sfla40_16x8bw16_if;
  import sfla_pkg::*;

  logic              i_cs;
  logic              i_flush;
  logic              i_vbe;
  logic              i_dcs;
  logic              i_wr;
  logic              i_rd;
  logic              i_cmp;
  logic [BITS-1:0]   i_di;
  logic [BITS-1:0]   i_mskb;
  logic              i_vbi;
  logic [ADDR_W-1:0] i_a;
  logic [BANKS-1:0]  i_cbe;
  logic [BITS-1:0]   o_do;
  logic              o_vbo;
  logic              o_hit;
  logic [WORDS-1:0]  o_hitline;

  modport master (
    output i_cs, i_flush, i_vbe, i_dcs, i_wr, i_rd, i_cmp,
           i_di, i_mskb, i_vbi, i_a, i_cbe,
    input  o_do, o_vbo, o_hit, o_hitline
  );

  modport slave (
    input  i_cs, i_flush, i_vbe, i_dcs, i_wr, i_rd, i_cmp,
           i_di, i_mskb, i_vbi, i_a, i_cbe,
    output o_do, o_vbo, o_hit, o_hitline
  );

endinterface

// File: rtl/sfla40_16x8bw16_match_line.sv
// One CAM line compare plus one link of the lowest-index priority chain.
// SFLA_HITLINE_PRIO_EN: suppress this line when any lower-index line already matched.
module sfla_match_line
  import sfla_pkg::*;
(
  input  entry_t          i_entry,
  input  logic [BITS-1:0] i_key,
  input  logic [BITS-1:0] i_mask,
  input  logic            i_above,
  output logic            o_line,
  output logic            o_above
);

  logic w_match;

  // A bit disagrees only when both the search mask and the stored care bit select it.
  assign w_match = i_entry.valid &&
                   (((i_entry.data ^ i_key) & i_entry.care & i_mask) == '0);

  assign o_above = i_above | w_match;

`ifdef SFLA_HITLINE_PRIO_EN
  assign o_line = w_match & ~i_above;
`else
  assign o_line = w_match;
`endif

endmodule

// File: rtl/sfla40_16x8bw16.sv
// sfla40_16x8bw16: 16x8 ternary CAM with bit-masked write, read, masked compare and flush.
// Optional macro SFLA_HITLINE_PRIO_EN makes HITLINE one-hot on the lowest-index match.
module sfla40_16x8bw16
  import sfla_pkg::*;
(
  input  logic             CK,
  input  logic             RST,
  sfla40_16x8bw16_if.slave bus
);

  entry_t           r_mem [WORDS];
  logic [BITS-1:0]  r_do;
  logic             r_vbo;
  logic             r_hit;
  logic [WORDS-1:0] r_hitline;

  op_t              w_op;
  logic             w_addr_ok;
  entry_t           w_sel;
  logic [WORDS-1:0] w_hitline;
  logic [WORDS:0]   w_above;

  assign w_op  = decode_op(bus.i_cs, bus.i_cbe, bus.i_flush, bus.i_wr, bus.i_rd, bus.i_cmp);
  assign w_sel = r_mem[bus.i_a];

  generate
    if (WORDS < (1 << ADDR_W)) begin : g_partial_map
      assign w_addr_ok = (32'(bus.i_a) < WORDS);
    end else begin : g_full_map
      assign w_addr_ok = 1'b1;
    end
  endgenerate

  // The chain's final carry is the OR of raw matches, which equals HIT in either HITLINE mode.
  assign w_above[0] = 1'b0;
  for (genvar i = 0; i < WORDS; i++) begin : g_line
    sfla_match_line u_line (
      .i_entry (r_mem[i]),
      .i_key   (bus.i_di),
      .i_mask  (bus.i_mskb),
      .i_above (w_above[i]),
      .o_line  (w_hitline[i]),
      .o_above (w_above[i+1])
    );
  end

  // NOTE: the array is flops, not SRAM, so the async reset may clear every entry at once.
  // NOTE: non-blocking assignments keep each edge's reads on pre-edge contents.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < WORDS; i++) r_mem[i] <= '0;
      r_do      <= '0;
      r_vbo     <= 1'b0;
      r_hit     <= 1'b0;
      r_hitline <= '0;
    end else begin
      case (w_op)
        OP_FLUSH: begin
          for (int i = 0; i < WORDS; i++) r_mem[i].valid <= 1'b0;
          r_hit     <= 1'b0;
          r_hitline <= '0;
        end
        OP_WR: begin
          if (w_addr_ok) begin
            if (bus.i_dcs)
              r_mem[bus.i_a].data <= (w_sel.data & ~bus.i_mskb) | (bus.i_di & bus.i_mskb);
            else
              r_mem[bus.i_a].care <= (w_sel.care & ~bus.i_mskb) | (bus.i_di & bus.i_mskb);
            if (bus.i_vbe) r_mem[bus.i_a].valid <= bus.i_vbi;
          end
        end
        OP_RD: begin
          r_do  <= !w_addr_ok ? '0 : (bus.i_dcs ? w_sel.data : w_sel.care);
          r_vbo <= w_addr_ok & bus.i_vbe & w_sel.valid;
        end
        OP_CMP: begin
          r_hit     <= w_above[WORDS];
          r_hitline <= w_hitline;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_do      = r_do;
  assign bus.o_vbo     = r_vbo;
  assign bus.o_hit     = r_hit;
  assign bus.o_hitline = r_hitline;

endmodule

// File: tb/tb_sfla40_16x8bw16.sv
// Directed bench for sfla40_16x8bw16: a behavioural CAM model checked every cycle plus literal spot checks.
module tb_sfla40_16x8bw16;
  import sfla_pkg::*;

  typedef struct {
    bit          cs, cbe, flush, wr, rd, cmp, vbe, dcs, vbi;
    logic [7:0]  di, mskb;
    logic [3:0]  a;
  } vec_t;

`ifdef SFLA_HITLINE_PRIO_EN
  localparam logic [15:0] HL_MULTI = 16'h0004;
  localparam logic [15:0] HL_ALL   = 16'h0004;
`else
  localparam logic [15:0] HL_MULTI = 16'h0084;
  localparam logic [15:0] HL_ALL   = 16'h008C;
`endif

  logic CK  = 1'b0;
  logic RST = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 1'b0;
  bit   done   = 1'b0;

  // Behavioural model state
  logic [7:0]  md [16];
  logic [7:0]  mk [16];
  bit          mv [16];
  logic [7:0]  e_do;
  logic        e_vbo;
  logic        e_hit;
  logic [15:0] e_hl;

  sfla40_16x8bw16_if bus ();

  sfla40_16x8bw16 dut (
    .CK  (CK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CK = ~CK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t idle_v();
    vec_t v;
    v = '{cs: 1'b0, cbe: 1'b0, flush: 1'b0, wr: 1'b0, rd: 1'b0, cmp: 1'b0,
          vbe: 1'b0, dcs: 1'b0, vbi: 1'b0, di: 8'h00, mskb: 8'h00, a: 4'h0};
    return v;
  endfunction

  function automatic vec_t wr_v(input logic [3:0] a, input bit dcs, input logic [7:0] di,
                                input logic [7:0] mskb, input bit vbe, input bit vbi);
    vec_t v = idle_v();
    v.cs = 1; v.wr = 1; v.a = a; v.dcs = dcs; v.di = di; v.mskb = mskb; v.vbe = vbe; v.vbi = vbi;
    return v;
  endfunction

  function automatic vec_t rd_v(input logic [3:0] a, input bit dcs, input bit vbe);
    vec_t v = idle_v();
    v.cs = 1; v.rd = 1; v.a = a; v.dcs = dcs; v.vbe = vbe;
    return v;
  endfunction

  function automatic vec_t cmp_v(input logic [7:0] di, input logic [7:0] mskb);
    vec_t v = idle_v();
    v.cs = 1; v.cmp = 1; v.di = di; v.mskb = mskb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.i_cs = v.cs;   bus.i_cbe = v.cbe;   bus.i_flush = v.flush;
    bus.i_wr = v.wr;   bus.i_rd  = v.rd;    bus.i_cmp   = v.cmp;
    bus.i_vbe = v.vbe; bus.i_dcs = v.dcs;   bus.i_vbi   = v.vbi;
    bus.i_di = v.di;   bus.i_mskb = v.mskb; bus.i_a     = v.a;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      md[i] = 8'h00; mk[i] = 8'h00; mv[i] = 1'b0;
    end
    e_do = 8'h00; e_vbo = 1'b0; e_hit = 1'b0; e_hl = 16'h0000;
  endtask

  // Applies the CAM's rules for one qualified edge.
  task automatic model_step(input vec_t v);
    logic [15:0] hl;
    bit          m;
    if (!v.cs || v.cbe) return;
    if (v.flush) begin
      for (int i = 0; i < 16; i++) mv[i] = 1'b0;
      e_hit = 1'b0; e_hl = 16'h0000;
    end else if (v.wr) begin
      for (int b = 0; b < 8; b++)
        if (v.mskb[b]) begin
          if (v.dcs) md[v.a][b] = v.di[b];
          else       mk[v.a][b] = v.di[b];
        end
      if (v.vbe) mv[v.a] = v.vbi;
    end else if (v.rd) begin
      e_do  = v.dcs ? md[v.a] : mk[v.a];
      e_vbo = v.vbe ? mv[v.a] : 1'b0;
    end else if (v.cmp) begin
      hl = 16'h0000;
      for (int i = 0; i < 16; i++) begin
        m = mv[i];
        for (int b = 0; b < 8; b++)
          if (v.mskb[b] && mk[i][b] && (md[i][b] != v.di[b])) m = 1'b0;
        hl[i] = m;
      end
      e_hit = (hl != 16'h0000);
`ifdef SFLA_HITLINE_PRIO_EN
      e_hl = hl & (~hl + 16'h0001);
`else
      e_hl = hl;
`endif
    end
  endtask

  task automatic run(input vec_t v);
    drive(v);
    @(posedge CK);
    model_step(v);
    @(negedge CK);
    drive(idle_v());
  endtask

  // Async reset asserted while an operation is on the bus.
  task automatic reset_mid(input vec_t v);
    drive(v);
    #2 RST = 1'b1;
    model_reset();
    @(posedge CK);
    @(negedge CK);
    #1 RST = 1'b0;
    drive(idle_v());
  endtask

  initial begin
    wait (mon_on);
    forever begin
      @(negedge CK);
      if (!done) begin
        check("mon_do",      32'(bus.o_do),      32'(e_do));
        check("mon_vbo",     32'(bus.o_vbo),     32'(e_vbo));
        check("mon_hit",     32'(bus.o_hit),     32'(e_hit));
        check("mon_hitline", 32'(bus.o_hitline), 32'(e_hl));
      end
    end
  end

  initial begin
    vec_t v;
    drive(idle_v());
    model_reset();
    #1 RST = 1'b1;
    mon_on = 1'b1;
    v = cmp_v(8'hA0, 8'hF0);
    drive(v);
    repeat (2) @(posedge CK);
    @(negedge CK);
    #1 RST = 1'b0;
    drive(idle_v());

    // Compare against an empty array after reset
    run(cmp_v(8'hA0, 8'hF0));
    check("rst_hit", 32'(bus.o_hit), 32'h0);
    check("rst_hitline", 32'(bus.o_hitline), 32'h0);
    check("rst_do", 32'(bus.o_do), 32'h0);
    check("rst_vbo", 32'(bus.o_vbo), 32'h0);

    // Entry 3: D=5C valid, K=F0
    run(wr_v(4'd3, 1, 8'h5C, 8'hFF, 1, 1));
    run(wr_v(4'd3, 0, 8'hF0, 8'hFF, 0, 0));
    run(cmp_v(8'h50, 8'hF0));
    check("e3_hit", 32'(bus.o_hit), 32'h1);
    check("e3_hitline", 32'(bus.o_hitline), 32'h0008);
    run(rd_v(4'd3, 1, 1));
    check("e3_do", 32'(bus.o_do), 32'h5C);
    check("e3_vbo", 32'(bus.o_vbo), 32'h1);

    // Bit-masked write on the low nibble; care mask must be untouched
    run(wr_v(4'd3, 1, 8'hFF, 8'h0F, 0, 0));
    run(rd_v(4'd3, 1, 1));
    check("bw_do", 32'(bus.o_do), 32'h5F);
    run(rd_v(4'd3, 0, 0));
    check("bw_care", 32'(bus.o_do), 32'hF0);
    check("bw_vbo_off", 32'(bus.o_vbo), 32'h0);

    // Entries 2 and 7 share the same upper nibble
    run(wr_v(4'd2, 1, 8'h30, 8'hFF, 1, 1));
    run(wr_v(4'd2, 0, 8'hF0, 8'hFF, 0, 0));
    run(wr_v(4'd7, 1, 8'h30, 8'hFF, 1, 1));
    run(wr_v(4'd7, 0, 8'hF0, 8'hFF, 0, 0));
    run(cmp_v(8'h3A, 8'hF0));
    check("multi_hitline", 32'(bus.o_hitline), 32'(HL_MULTI));
    check("multi_hit", 32'(bus.o_hit), 32'h1);
    run(cmp_v(8'h00, 8'h00));
    check("nomask_hitline", 32'(bus.o_hitline), 32'(HL_ALL));
    run(rd_v(4'd7, 1, 1));
    check("hold_hitline_rd", 32'(bus.o_hitline), 32'(HL_ALL));

    // Flush clears valid bits and hits, keeps data
    v = idle_v(); v.cs = 1; v.flush = 1;
    run(v);
    check("fl_hitline", 32'(bus.o_hitline), 32'h0);
    check("fl_do_hold", 32'(bus.o_do), 32'h30);
    run(cmp_v(8'h3A, 8'hF0));
    check("fl_cmp_hit", 32'(bus.o_hit), 32'h0);
    run(rd_v(4'd2, 1, 1));
    check("fl_rd_do", 32'(bus.o_do), 32'h30);
    check("fl_rd_vbo", 32'(bus.o_vbo), 32'h0);

    // Valid-only write (MSKB=0)
    run(wr_v(4'd2, 1, 8'h00, 8'h00, 1, 1));
    run(cmp_v(8'h3A, 8'hF0));
    check("vonly_hitline", 32'(bus.o_hitline), 32'h0004);
    run(rd_v(4'd2, 1, 1));
    check("vonly_do", 32'(bus.o_do), 32'h30);

    // Bank disabled and chip deselected: write ignored
    v = wr_v(4'd2, 1, 8'h00, 8'hFF, 1, 0); v.cbe = 1;
    run(v);
    v = wr_v(4'd2, 1, 8'h00, 8'hFF, 1, 0); v.cs = 0;
    run(v);
    run(rd_v(4'd2, 1, 1));
    check("cbe_do", 32'(bus.o_do), 32'h30);
    check("cbe_vbo", 32'(bus.o_vbo), 32'h1);

    // WR and CMP together: write wins, hits hold
    v = wr_v(4'd7, 1, 8'h00, 8'h00, 1, 1); v.cmp = 1;
    run(v);
    check("wrcmp_hold", 32'(bus.o_hitline), 32'h0004);
    run(cmp_v(8'h3A, 8'hF0));
    check("wrcmp_after", 32'(bus.o_hitline), 32'(HL_MULTI));

    // Top entry boundary
    run(wr_v(4'd15, 1, 8'hAA, 8'hFF, 1, 1));
    run(wr_v(4'd15, 0, 8'hFF, 8'hFF, 0, 0));
    run(cmp_v(8'hAA, 8'hFF));
    check("top_hitline", 32'(bus.o_hitline), 32'h8000);
    run(rd_v(4'd15, 1, 1));
    check("top_do", 32'(bus.o_do), 32'hAA);

    // FLUSH outranks WR on the same edge
    v = wr_v(4'd2, 1, 8'h00, 8'hFF, 1, 1); v.flush = 1;
    run(v);
    run(rd_v(4'd2, 1, 1));
    check("flwr_do", 32'(bus.o_do), 32'h30);
    check("flwr_vbo", 32'(bus.o_vbo), 32'h0);

    // Reset mid-write aborts the write and clears the arrays
    run(wr_v(4'd15, 1, 8'hAA, 8'hFF, 1, 1));
    reset_mid(wr_v(4'd15, 1, 8'h55, 8'hFF, 1, 1));
    run(rd_v(4'd15, 1, 1));
    check("rstmid_do", 32'(bus.o_do), 32'h0);
    check("rstmid_vbo", 32'(bus.o_vbo), 32'h0);
    run(rd_v(4'd2, 0, 1));
    check("rstmid_care", 32'(bus.o_do), 32'h0);
    run(cmp_v(8'h00, 8'h00));
    check("rstmid_hit", 32'(bus.o_hit), 32'h0);

    done = 1'b1;
    @(negedge CK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
